// File: rtl/ctrl_transaccion.sv
// Transaction-layer controller: sequences RESET/INIT/IDLE/ACTIVE/ERROR and latches FIFO thresholds.
// Optional macro CTRL_ERROR_CAPTURE_EN builds a register that snapshots error_fifo on ERROR entry.
module ctrl_transaccion #(
    parameter int unsigned TH_WIDTH  = 3,
    parameter int unsigned IDLE_WAIT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [TH_WIDTH-1:0] umbral_af_in,
    input  logic [TH_WIDTH-1:0] umbral_ae_in,
    input  logic [3:0]          empty_in,
    input  logic [3:0]          empty_out,
    input  logic [7:0]          error_fifo,
    output logic [2:0]          state,
    output logic [TH_WIDTH-1:0] umbral_af,
    output logic [TH_WIDTH-1:0] umbral_ae,
    output logic                idle_out,
    output logic                active_out,
    output logic                error_out,
    output logic                arb_enable,
    output logic [7:0]          error_src
);

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StInit   = 3'd1,
        StIdle   = 3'd2,
        StActive = 3'd3,
        StError  = 3'd4
    } state_e;

    localparam logic [3:0] WaitLast = 4'(IDLE_WAIT - 1);

    state_e              state_q, state_d;
    logic [3:0]          idle_cnt_q, idle_cnt_d;
    logic [TH_WIDTH-1:0] af_q, af_d;
    logic [TH_WIDTH-1:0] ae_q, ae_d;

    logic all_empty;
    logic any_error;
    logic cfg_valid;

    assign all_empty = (empty_in == 4'hF) && (empty_out == 4'hF);
    assign any_error = |error_fifo;
    assign cfg_valid = umbral_ae_in < umbral_af_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StReset;
            idle_cnt_q <= '0;
            af_q       <= '0;
            ae_q       <= '0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StReset: state_d = StInit;
            StInit: begin
                if (!init && cfg_valid) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (any_error) begin
                    state_d = StError;
                end else if (init) begin
                    state_d = StInit;
                end else if (empty_in != 4'hF) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (any_error) begin
                    state_d = StError;
                end else if (init) begin
                    state_d = StInit;
                end else if (all_empty && (idle_cnt_q == WaitLast)) begin
                    state_d = StIdle;
                end
            end
            StError: state_d = StError;
            default: state_d = StReset;
        endcase
    end

    // Counter only survives while staying in ACTIVE, so every entry sees it cleared.
    always_comb begin
        idle_cnt_d = '0;
        if ((state_q == StActive) && (state_d == StActive) && all_empty) begin
            idle_cnt_d = (idle_cnt_q == 4'hF) ? idle_cnt_q : idle_cnt_q + 4'd1;
        end
    end

    always_comb begin
        af_d = af_q;
        ae_d = ae_q;
        if (state_q == StInit) begin
            af_d = umbral_af_in;
            ae_d = umbral_ae_in;
        end
    end

    always_comb begin
        state      = state_q;
        idle_out   = (state_q == StIdle);
        active_out = (state_q == StActive);
        error_out  = (state_q == StError);
        arb_enable = (state_q == StActive);
        umbral_af  = af_q;
        umbral_ae  = ae_q;
    end

`ifdef CTRL_ERROR_CAPTURE_EN
    logic [7:0] error_src_q, error_src_d;

    always_comb begin
        error_src_d = error_src_q;
        if ((state_q != StError) && (state_d == StError)) begin
            error_src_d = error_fifo;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_src_q <= '0;
        end else begin
            error_src_q <= error_src_d;
        end
    end

    assign error_src = error_src_q;
`else
    assign error_src = 8'h00;
`endif

endmodule

// File: tb/tb_ctrl_transaccion.sv
// Directed plus randomized bench for ctrl_transaccion against a rule-level reference model.
module tb_ctrl_transaccion;

    localparam int unsigned TW = 3;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          init;
    logic [TW-1:0] umbral_af_in;
    logic [TW-1:0] umbral_ae_in;
    logic [3:0]    empty_in;
    logic [3:0]    empty_out;
    logic [7:0]    error_fifo;
    logic [2:0]    state;
    logic [TW-1:0] umbral_af;
    logic [TW-1:0] umbral_ae;
    logic          idle_out;
    logic          active_out;
    logic          error_out;
    logic          arb_enable;
    logic [7:0]    error_src;

    int checks   = 0;
    int failures = 0;

    // Reference model state: phase number and length of the current all-empty run in ACTIVE.
    int            m_state = 0;
    int            m_run   = 0;
    logic [TW-1:0] m_af    = '0;
    logic [TW-1:0] m_ae    = '0;
    logic [7:0]    m_src   = '0;

    ctrl_transaccion #(
        .TH_WIDTH (TW),
        .IDLE_WAIT(IW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .umbral_af_in(umbral_af_in),
        .umbral_ae_in(umbral_ae_in),
        .empty_in    (empty_in),
        .empty_out   (empty_out),
        .error_fifo  (error_fifo),
        .state       (state),
        .umbral_af   (umbral_af),
        .umbral_ae   (umbral_ae),
        .idle_out    (idle_out),
        .active_out  (active_out),
        .error_out   (error_out),
        .arb_enable  (arb_enable),
        .error_src   (error_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_state = 0;
            m_run   = 0;
            m_af    = '0;
            m_ae    = '0;
            m_src   = '0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            m_af = umbral_af_in;
            m_ae = umbral_ae_in;
            if (!init && (umbral_ae_in < umbral_af_in)) m_state = 2;
        end else if (m_state == 2 || m_state == 3) begin
            if (error_fifo != 8'h00) begin
                m_state = 4;
`ifdef CTRL_ERROR_CAPTURE_EN
                m_src = error_fifo;
`endif
            end else if (init) begin
                m_state = 1;
            end else if (m_state == 2) begin
                if (empty_in != 4'hF) begin
                    m_state = 3;
                    m_run   = 0;
                end
            end else if (empty_in == 4'hF && empty_out == 4'hF) begin
                m_run = m_run + 1;
                if (m_run >= int'(IW)) m_state = 2;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".af"}, 32'(umbral_af), 32'(m_af));
        chk({tag, ".ae"}, 32'(umbral_ae), 32'(m_ae));
        chk({tag, ".idle"}, 32'(idle_out), 32'(m_state == 2));
        chk({tag, ".active"}, 32'(active_out), 32'(m_state == 3));
        chk({tag, ".error"}, 32'(error_out), 32'(m_state == 4));
        chk({tag, ".arb"}, 32'(arb_enable), 32'(m_state == 3));
        chk({tag, ".src"}, 32'(error_src), 32'(m_src));
    endtask

    initial begin
        reset        = 1'b1;
        init         = 1'b0;
        umbral_af_in = '0;
        umbral_ae_in = '0;
        empty_in     = 4'hF;
        empty_out    = 4'hF;
        error_fifo   = 8'h00;

        for (int i = 0; i < 3; i++) step("rst");
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_af", 32'(umbral_af), 32'd0);
        reset = 1'b0;
        step("rel");
        chk("rel_state", 32'(state), 32'd1);

        umbral_af_in = 3'd6;
        umbral_ae_in = 3'd1;
        init         = 1'b1;
        step("init_hold");
        step("init_hold");
        init = 1'b0;
        step("init_go");
        chk("init_go_state", 32'(state), 32'd2);
        chk("init_go_af", 32'(umbral_af), 32'd6);
        chk("init_go_ae", 32'(umbral_ae), 32'd1);

        init = 1'b1;
        step("back_init");
        umbral_af_in = 3'd3;
        umbral_ae_in = 3'd5;
        init         = 1'b0;
        step("bad_cfg");
        chk("bad_cfg_state", 32'(state), 32'd1);
        chk("bad_cfg_ae", 32'(umbral_ae), 32'd5);
        umbral_ae_in = 3'd1;
        step("fix_cfg");
        chk("fix_cfg_state", 32'(state), 32'd2);

        empty_in = 4'hE;
        step("to_active");
        chk("to_active_arb", 32'(arb_enable), 32'd1);
        empty_in = 4'hF;
        step("empty1");
        chk("empty1_state", 32'(state), 32'd3);
        step("empty2");
        chk("empty2_state", 32'(state), 32'd2);

        empty_in = 4'hE;
        step("re_active");
        empty_in = 4'hF;
        step("run_a1");
        empty_in = 4'hB;
        step("run_break");
        empty_in = 4'hF;
        step("run_b1");
        chk("run_b1_state", 32'(state), 32'd3);
        step("run_b2");
        chk("run_b2_state", 32'(state), 32'd2);

        empty_in = 4'hE;
        step("err_pre");
        error_fifo = 8'h20;
        init       = 1'b1;
        step("err");
        chk("err_state", 32'(state), 32'd4);
        chk("err_arb", 32'(arb_enable), 32'd0);
`ifdef CTRL_ERROR_CAPTURE_EN
        chk("err_src", 32'(error_src), 32'h20);
`else
        chk("err_src", 32'(error_src), 32'h00);
`endif
        error_fifo = 8'h00;
        init       = 1'b0;
        step("err_stick");
        init = 1'b1;
        step("err_init");
        chk("err_init_state", 32'(state), 32'd4);
        init  = 1'b0;
        reset = 1'b1;
        step("err_rst");
        chk("err_rst_src", 32'(error_src), 32'd0);
        reset = 1'b0;

        umbral_af_in = 3'd6;
        umbral_ae_in = 3'd1;
        step("re_init");
        step("re_idle");
        empty_in = 4'h7;
        step("act2");
        reset = 1'b1;
        step("mid_rst");
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_af", 32'(umbral_af), 32'd0);
        reset = 1'b0;
        step("reload_init");
        step("reload_idle");
        chk("reload_af", 32'(umbral_af), 32'd6);

        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 39) == 0);
            init         = ($urandom_range(0, 7) == 0);
            umbral_af_in = TW'($urandom);
            umbral_ae_in = TW'($urandom);
            empty_in     = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
            empty_out    = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
            error_fifo   = ($urandom_range(0, 29) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
